// File: rtl/sid_regs_pkg.sv
// Shared definitions for the SID CPU-facing register file.
// Holds the $D400-$D41F address map (5-bit offsets), the per-voice register offsets,
// the packed per-voice register record and small address-decode helpers.
package sid_regs_pkg;

  localparam logic [4:0] SID_V1_BASE  = 5'h00;
  localparam logic [4:0] SID_V2_BASE  = 5'h07;
  localparam logic [4:0] SID_V3_BASE  = 5'h0E;
  localparam logic [4:0] SID_FC_LO    = 5'h15;
  localparam logic [4:0] SID_FC_HI    = 5'h16;
  localparam logic [4:0] SID_RES_FILT = 5'h17;
  localparam logic [4:0] SID_MODE_VOL = 5'h18;
  localparam logic [4:0] SID_POTX     = 5'h19;
  localparam logic [4:0] SID_POTY     = 5'h1A;
  localparam logic [4:0] SID_OSC3     = 5'h1B;
  localparam logic [4:0] SID_ENV3     = 5'h1C;

  // Offsets within one voice's 7-register block.
  localparam logic [2:0] SID_OFS_FREQ_LO = 3'd0;
  localparam logic [2:0] SID_OFS_FREQ_HI = 3'd1;
  localparam logic [2:0] SID_OFS_PW_LO   = 3'd2;
  localparam logic [2:0] SID_OFS_PW_HI   = 3'd3;
  localparam logic [2:0] SID_OFS_CONTROL = 3'd4;
  localparam logic [2:0] SID_OFS_ATT_DEC = 3'd5;
  localparam logic [2:0] SID_OFS_SUS_REL = 3'd6;

  typedef struct packed {
    logic [15:0] freq;
    logic [11:0] pw;
    logic [7:0]  control;
    logic [7:0]  att_dec;
    logic [7:0]  sus_rel;
  } sid_voice_regs_t;

  // Voice index 0..2 for a voice register address, 3 for anything else.
  function automatic logic [1:0] sid_voice_index(input logic [4:0] a);
    logic [1:0] idx;
    if (a < SID_V2_BASE) begin
      idx = 2'd0;
    end else if (a < SID_V3_BASE) begin
      idx = 2'd1;
    end else if (a < SID_FC_LO) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // Offset of a voice register address within its block.
  function automatic logic [2:0] sid_voice_offset(input logic [4:0] a);
    logic [4:0] rel;
    if (a < SID_V2_BASE) begin
      rel = a - SID_V1_BASE;
    end else if (a < SID_V3_BASE) begin
      rel = a - SID_V2_BASE;
    end else begin
      rel = a - SID_V3_BASE;
    end
    return rel[2:0];
  endfunction

endpackage

// File: rtl/sid_pot_sampler.sv
// One paddle axis of the pot sampling sequencer.
// The shared phase counter lives in the parent so both axes stay aligned; while its MSB is 0
// the capacitor is discharged, while it is 1 the first comparator hit captures phase[7:0].
// At phase wrap the captured value (or 8'hFF if never hit) becomes the visible pot value.
// Ports:
//   clock_i, reset_i  clock, synchronous active-high reset
//   ce_1m_i           1 MHz tick enable
//   phase_i           shared phase counter
//   cmp_i             comparator, 1 = capacitor charged past threshold
//   pot_o             last completed sample
module sid_pot_sampler #(
  parameter int unsigned PhaseW = 9
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              ce_1m_i,
  input  logic [PhaseW-1:0] phase_i,
  input  logic              cmp_i,
  output logic [7:0]        pot_o
);

  logic       captured_q, captured_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] pot_q, pot_d;

  always_comb begin
    captured_d = captured_q;
    pending_d  = pending_q;
    pot_d      = pot_q;
    if (ce_1m_i) begin
      if (!phase_i[PhaseW-1]) begin
        captured_d = 1'b0;
      end else if (cmp_i && !captured_q) begin
        pending_d  = phase_i[7:0];
        captured_d = 1'b1;
      end
      // Use next-state so a hit on the very last count tick is still reported.
      if (&phase_i) begin
        pot_d = captured_d ? pending_d : 8'hFF;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      captured_q <= 1'b0;
      pending_q  <= 8'h00;
      pot_q      <= 8'h00;
    end else begin
      captured_q <= captured_d;
      pending_q  <= pending_d;
      pot_q      <= pot_d;
    end
  end

  assign pot_o = pot_q;

endmodule

// File: rtl/sid_bus_regs.sv
// CPU-facing register file for the SID core.
// Decodes 6502 accesses at $D400-$D41F, holds the write-only voice/filter/volume registers,
// returns POTX/POTY/OSC3/ENV3 and otherwise the decaying bus-latch value, and (with
// SID_POT_EN defined) contains the paddle sampling sequencer. Without SID_POT_EN, POTX/POTY
// read 8'hFF, pot_discharge is 0 and the comparators are ignored.
// Ports:
//   clock, reset             clock, synchronous active-high reset
//   ce_1m                    1 MHz phi2 tick enable (decay and pot timing only)
//   cs, we, addr, data_in    bus access, one per clock when cs is high
//   data_out                 registered read data, 1 clock latency, holds between reads
//   osc3, env3               voice-3 live values for read-back
//   pot_x_cmp, pot_y_cmp     pot comparators
//   pot_discharge            1 = discharge both pot capacitors
//   freq, pw, control, att_dec, sus_rel   {v3,v2,v1} voice registers
//   fc, res_filt, mode_vol   filter and volume registers
module sid_bus_regs
  import sid_regs_pkg::*;
#(
  parameter int unsigned DECAY_TICKS     = 8192,
  parameter int unsigned POT_PERIOD_LOG2 = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce_1m,
  input  logic        cs,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic [7:0]  osc3,
  input  logic [7:0]  env3,
  input  logic        pot_x_cmp,
  input  logic        pot_y_cmp,
  output logic        pot_discharge,
  output logic [47:0] freq,
  output logic [35:0] pw,
  output logic [23:0] control,
  output logic [23:0] att_dec,
  output logic [23:0] sus_rel,
  output logic [10:0] fc,
  output logic [7:0]  res_filt,
  output logic [7:0]  mode_vol
);

  localparam int unsigned DecayW = $clog2(DECAY_TICKS + 1);
  localparam logic [DecayW-1:0] DecayLoad = DecayW'(DECAY_TICKS);

  sid_voice_regs_t voice_q [3];
  sid_voice_regs_t voice_d [3];
  logic [10:0]       fc_q, fc_d;
  logic [7:0]        res_filt_q, res_filt_d;
  logic [7:0]        mode_vol_q, mode_vol_d;
  logic [7:0]        latch_q, latch_d;
  logic [DecayW-1:0] decay_q, decay_d;
  logic [7:0]        data_out_q, data_out_d;

  logic [7:0] potx, poty;
  logic       wr, rd;
  logic [1:0] vidx;
  logic [2:0] vofs;
  logic       ro_hit;
  logic [7:0] ro_val;

  assign wr   = cs & we;
  assign rd   = cs & ~we;
  assign vidx = sid_voice_index(addr);
  assign vofs = sid_voice_offset(addr);

  // Register writes: any clock, independent of ce_1m.
  always_comb begin
    voice_d    = voice_q;
    fc_d       = fc_q;
    res_filt_d = res_filt_q;
    mode_vol_d = mode_vol_q;
    if (wr) begin
      for (int v = 0; v < 3; v++) begin
        if (vidx == 2'(v)) begin
          case (vofs)
            SID_OFS_FREQ_LO: voice_d[v].freq[7:0]  = data_in;
            SID_OFS_FREQ_HI: voice_d[v].freq[15:8] = data_in;
            SID_OFS_PW_LO:   voice_d[v].pw[7:0]    = data_in;
            SID_OFS_PW_HI:   voice_d[v].pw[11:8]   = data_in[3:0];
            SID_OFS_CONTROL: voice_d[v].control    = data_in;
            SID_OFS_ATT_DEC: voice_d[v].att_dec    = data_in;
            SID_OFS_SUS_REL: voice_d[v].sus_rel    = data_in;
            default: ;
          endcase
        end
      end
      case (addr)
        SID_FC_LO:    fc_d[2:0]  = data_in[2:0];
        SID_FC_HI:    fc_d[10:3] = data_in;
        SID_RES_FILT: res_filt_d = data_in;
        SID_MODE_VOL: mode_vol_d = data_in;
        default: ;
      endcase
    end
  end

  // Read-only register mux.
  always_comb begin
    ro_hit = 1'b1;
    ro_val = 8'h00;
    case (addr)
      SID_POTX: ro_val = potx;
      SID_POTY: ro_val = poty;
      SID_OSC3: ro_val = osc3;
      SID_ENV3: ro_val = env3;
      default:  ro_hit = 1'b0;
    endcase
  end

  // Bus latch with decay; a latching access in the same clock as expiry overrides the clear.
  always_comb begin
    latch_d    = latch_q;
    decay_d    = decay_q;
    data_out_d = data_out_q;
    if (ce_1m && (decay_q != '0)) begin
      decay_d = decay_q - DecayW'(1);
      if (decay_q == DecayW'(1)) begin
        latch_d = 8'h00;
      end
    end
    if (wr) begin
      latch_d = data_in;
      decay_d = DecayLoad;
    end else if (rd && ro_hit) begin
      latch_d = ro_val;
      decay_d = DecayLoad;
    end
    if (rd) begin
      data_out_d = ro_hit ? ro_val : latch_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int v = 0; v < 3; v++) begin
        voice_q[v] <= '0;
      end
      fc_q       <= '0;
      res_filt_q <= '0;
      mode_vol_q <= '0;
      latch_q    <= '0;
      decay_q    <= '0;
      data_out_q <= '0;
    end else begin
      voice_q    <= voice_d;
      fc_q       <= fc_d;
      res_filt_q <= res_filt_d;
      mode_vol_q <= mode_vol_d;
      latch_q    <= latch_d;
      decay_q    <= decay_d;
      data_out_q <= data_out_d;
    end
  end

`ifdef SID_POT_EN
  logic [POT_PERIOD_LOG2-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (ce_1m) begin
      phase_d = phase_q + POT_PERIOD_LOG2'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign pot_discharge = ~phase_q[POT_PERIOD_LOG2-1];

  sid_pot_sampler #(
    .PhaseW (POT_PERIOD_LOG2)
  ) u_pot_x (
    .clock_i (clock),
    .reset_i (reset),
    .ce_1m_i (ce_1m),
    .phase_i (phase_q),
    .cmp_i   (pot_x_cmp),
    .pot_o   (potx)
  );

  sid_pot_sampler #(
    .PhaseW (POT_PERIOD_LOG2)
  ) u_pot_y (
    .clock_i (clock),
    .reset_i (reset),
    .ce_1m_i (ce_1m),
    .phase_i (phase_q),
    .cmp_i   (pot_y_cmp),
    .pot_o   (poty)
  );
`else
  logic                       unused_pot_cmp;
  logic [POT_PERIOD_LOG2-1:0] unused_pot_phase;

  assign unused_pot_cmp   = pot_x_cmp ^ pot_y_cmp;
  assign unused_pot_phase = '0;
  assign potx             = 8'hFF;
  assign poty             = 8'hFF;
  assign pot_discharge    = 1'b0;
`endif

  assign freq     = {voice_q[2].freq, voice_q[1].freq, voice_q[0].freq};
  assign pw       = {voice_q[2].pw, voice_q[1].pw, voice_q[0].pw};
  assign control  = {voice_q[2].control, voice_q[1].control, voice_q[0].control};
  assign att_dec  = {voice_q[2].att_dec, voice_q[1].att_dec, voice_q[0].att_dec};
  assign sus_rel  = {voice_q[2].sus_rel, voice_q[1].sus_rel, voice_q[0].sus_rel};
  assign fc       = fc_q;
  assign res_filt = res_filt_q;
  assign mode_vol = mode_vol_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_sid_bus_regs.sv
module tb_sid_bus_regs;

  localparam int unsigned Decay = 8192;

`ifdef SID_POT_EN
  localparam logic [7:0] PotAfterReset = 8'h00;
  localparam logic       DisAfterReset = 1'b1;
`else
  localparam logic [7:0] PotAfterReset = 8'hFF;
  localparam logic       DisAfterReset = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ce_1m = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic [7:0]  osc3 = '0;
  logic [7:0]  env3 = '0;
  logic        pot_x_cmp = 1'b0;
  logic        pot_y_cmp = 1'b0;
  logic        pot_discharge;
  logic [47:0] freq;
  logic [35:0] pw;
  logic [23:0] control;
  logic [23:0] att_dec;
  logic [23:0] sus_rel;
  logic [10:0] fc;
  logic [7:0]  res_filt;
  logic [7:0]  mode_vol;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  sid_bus_regs dut (
    .clock         (clock),
    .reset         (reset),
    .ce_1m         (ce_1m),
    .cs            (cs),
    .we            (we),
    .addr          (addr),
    .data_in       (data_in),
    .data_out      (data_out),
    .osc3          (osc3),
    .env3          (env3),
    .pot_x_cmp     (pot_x_cmp),
    .pot_y_cmp     (pot_y_cmp),
    .pot_discharge (pot_discharge),
    .freq          (freq),
    .pw            (pw),
    .control       (control),
    .att_dec       (att_dec),
    .sus_rel       (sus_rel),
    .fc            (fc),
    .res_filt      (res_filt),
    .mode_vol      (mode_vol)
  );

  always #5 clock = ~clock;

  // One clock with the given bus/tick inputs; returns #1 after the edge.
  task automatic step(input logic c, input logic w, input logic [4:0] a, input logic [7:0] d,
                      input logic ce);
    cs = c; we = w; addr = a; data_in = d; ce_1m = ce;
    @(posedge clock);
    #1;
    cs = 1'b0; we = 1'b0; ce_1m = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, a, d, 1'b0);
  endtask

  // Expected value is pushed by the caller when the read is issued.
  task automatic bus_read(input logic [4:0] a, input string name);
    logic [7:0] e;
    step(1'b1, 1'b0, a, 8'h00, 1'b0);
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: no expected value queued, got %02h", name, data_out);
    end else begin
      e = exp_q.pop_front();
      tests++;
      if (data_out !== e) begin
        fails++;
        $display("FAIL %s: data_out=%02h expected %02h", name, data_out, e);
      end
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step(1'b0, 1'b0, 5'h00, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if ({freq, pw, control, att_dec, sus_rel, fc, res_filt, mode_vol, data_out} !== '0) begin
      fails++;
      $display("FAIL %s: regs freq=%h pw=%h ctl=%h ad=%h sr=%h fc=%h rf=%h mv=%h do=%h expected 0",
               name, freq, pw, control, att_dec, sus_rel, fc, res_filt, mode_vol, data_out);
    end
    tests++;
    if (pot_discharge !== DisAfterReset) begin
      fails++;
      $display("FAIL %s_discharge: got %b expected %b", name, pot_discharge, DisAfterReset);
    end
  endtask

  task automatic test_reset;
    do_reset();
    check_all_zero("reset");
    exp_q.push_back(8'h00);
    bus_read(5'h1D, "reset_latch");
    exp_q.push_back(PotAfterReset);
    bus_read(5'h19, "reset_potx");
  endtask

  task automatic test_write;
    bus_write(5'h00, 8'h34);
    bus_write(5'h01, 8'h12);
    bus_write(5'h04, 8'h41);
    tests++;
    if (freq[15:0] !== 16'h1234 || control[7:0] !== 8'h41) begin
      fails++;
      $display("FAIL v1_write: freq=%h control=%h expected 1234/41", freq[15:0], control[7:0]);
    end
    tests++;
    if (freq[47:16] !== '0 || control[23:8] !== '0) begin
      fails++;
      $display("FAIL other_voices: freq=%h control=%h expected 0", freq[47:16], control[23:8]);
    end
    bus_write(5'h0E, 8'hAB);
    bus_write(5'h0C, 8'h5A);
    tests++;
    if (freq[39:32] !== 8'hAB || att_dec[15:8] !== 8'h5A) begin
      fails++;
      $display("FAIL v3_v2_write: freq3lo=%h ad2=%h expected AB/5A", freq[39:32], att_dec[15:8]);
    end
    bus_write(5'h15, 8'hFF);
    bus_write(5'h16, 8'h80);
    bus_write(5'h17, 8'hA3);
    bus_write(5'h18, 8'h5F);
    tests++;
    if (fc !== 11'h407 || res_filt !== 8'hA3 || mode_vol !== 8'h5F) begin
      fails++;
      $display("FAIL filter_write: fc=%h rf=%h mv=%h expected 407/A3/5F", fc, res_filt, mode_vol);
    end
    bus_write(5'h03, 8'hFA);
    tests++;
    if (pw[11:0] !== 12'hA00) begin
      fails++;
      $display("FAIL pw_hi: pw=%h expected A00", pw[11:0]);
    end
    exp_q.push_back(8'hFA);
    bus_read(5'h03, "writeonly_read_latch");
    bus_write(5'h19, 8'h3C);
    exp_q.push_back(8'h3C);
    bus_read(5'h1D, "ro_write_latch");
    exp_q.push_back(PotAfterReset);
    bus_read(5'h19, "ro_write_no_effect");
  endtask

  task automatic test_decay;
    bus_write(5'h18, 8'h5F);
    ticks(Decay - 1);
    exp_q.push_back(8'h5F);
    bus_read(5'h1D, "decay_before");
    ticks(1);
    exp_q.push_back(8'h00);
    bus_read(5'h1D, "decay_after");
    bus_write(5'h18, 8'h5F);
    ticks(Decay - 1);
    step(1'b1, 1'b1, 5'h05, 8'h77, 1'b1);
    exp_q.push_back(8'h77);
    bus_read(5'h1D, "decay_write_wins");
    tests++;
    if (att_dec[7:0] !== 8'h77) begin
      fails++;
      $display("FAIL decay_write_reg: att_dec=%h expected 77", att_dec[7:0]);
    end
  endtask

  task automatic test_readonly;
    osc3 = 8'hA5;
    env3 = 8'h3E;
    exp_q.push_back(8'hA5);
    bus_read(5'h1B, "osc3_read");
    exp_q.push_back(8'hA5);
    bus_read(5'h1E, "osc3_latched");
    exp_q.push_back(8'h3E);
    bus_read(5'h1C, "env3_read");
    exp_q.push_back(8'h3E);
    bus_read(5'h01, "env3_latched");
    // data_out holds when there is no read.
    bus_write(5'h02, 8'h11);
    step(1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
    tests++;
    if (data_out !== 8'h3E) begin
      fails++;
      $display("FAIL data_out_hold: got %02h expected 3E", data_out);
    end
  endtask

  task automatic test_pot;
`ifdef SID_POT_EN
    logic exp_dis;
    do_reset();
    pot_x_cmp = 1'b0;
    pot_y_cmp = 1'b0;
    for (int t = 0; t < 512; t++) begin
      exp_dis = (t < 256);
      tests++;
      if (pot_discharge !== exp_dis) begin
        fails++;
        $display("FAIL pot_discharge_t%0d: got %b expected %b", t, pot_discharge, exp_dis);
      end
      if (t == 356) pot_x_cmp = 1'b1;
      if (t == 400) begin
        exp_q.push_back(8'h00);
        bus_read(5'h19, "pot_midperiod");
      end
      ticks(1);
    end
    exp_q.push_back(8'h64);
    bus_read(5'h19, "potx_sample");
    exp_q.push_back(8'hFF);
    bus_read(5'h1A, "poty_never");
    // Comparator already high when counting starts yields 0.
    ticks(512);
    exp_q.push_back(8'h00);
    bus_read(5'h19, "potx_early_high");
    pot_x_cmp = 1'b0;
`else
    pot_x_cmp = 1'b1;
    pot_y_cmp = 1'b1;
    ticks(300);
    tests++;
    if (pot_discharge !== 1'b0) begin
      fails++;
      $display("FAIL pot_discharge_off: got %b expected 0", pot_discharge);
    end
    exp_q.push_back(8'hFF);
    bus_read(5'h19, "potx_const");
    exp_q.push_back(8'hFF);
    bus_read(5'h1A, "poty_const");
    pot_x_cmp = 1'b0;
    pot_y_cmp = 1'b0;
`endif
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus_write(5'h00, 8'h99);
    bus_write(5'h12, 8'h44);
    bus_write(5'h16, 8'hC3);
    ticks(300);
    osc3 = 8'h5C;
    exp_q.push_back(8'h5C);
    bus_read(5'h1B, "pre_reset_read");
    do_reset();
    check_all_zero("reset_mid");
    ticks(511);
    exp_q.push_back(PotAfterReset);
    bus_read(5'h19, "potx_before_period");
    ticks(1);
    exp_q.push_back(8'hFF);
    bus_read(5'h19, "potx_after_period");
  endtask

  initial begin
    test_reset();
    test_write();
    test_decay();
    test_readonly();
    test_pot();
    test_reset_mid();
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_drain: %0d expected values left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
